alu_multicycle: RTL

Parametrised successor to the single-cycle 2-bit-opcode ALU in the execute stage. Adds a 16-op ARM-style set: ADC/SBC/RSB, EOR/BIC/MOV/MVN, barrel shifts and an iterative shift-add MUL. It also adds a valid/ready input handshake, a registered result and an internal NZCV flag register updated under an S-bit. Codes 0000–0011 keep the legacy ADD/SUB/AND/ORR encoding.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_shifter.sv | 40 ++++
 rtl/alu_multicycle.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the multicycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_ORR = 4'b0011,
    OP_EOR = 4'b0100,
    OP_ADC = 4'b0101,
    OP_SBC = 4'b0110,
    OP_RSB = 4'b0111,
    OP_LSL = 4'b1000,
    OP_LSR = 4'b1001,
    OP_ASR = 4'b1010,
    OP_ROR = 4'b1011,
    OP_MUL = 4'b1100,
    OP_BIC = 4'b1101,
    OP_MOV = 4'b1110,
    OP_MVN = 4'b1111
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter (LSL/LSR/ASR/ROR) with shifted-out carry.
// An amount of zero passes data through and keeps the incoming carry.
module alu_shifter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         i_data,
  input  logic [$clog2(WIDTH)-1:0] i_amount,
  input  logic [1:0]               i_type,
  input  logic                     i_cin,
  output logic [WIDTH-1:0]         o_result,
  output logic                     o_cout
);

  logic [WIDTH:0]     w_lsl;
  logic [WIDTH:0]     w_lsr;
  logic [WIDTH:0]     w_asr;
  logic [2*WIDTH-1:0] w_ror;
  logic [WIDTH-1:0]   w_res_raw;
  logic               w_cout_raw;

  // Each variant carries one guard bit that catches the last bit shifted out.
  always_comb begin
    w_lsl = {1'b0, i_data} << i_amount;
    w_lsr = {i_data, 1'b0} >> i_amount;
    w_asr = $signed({i_data, 1'b0}) >>> i_amount;
    w_ror = {i_data, i_data} >> i_amount;
    w_res_raw  = i_data;
    w_cout_raw = i_cin;
    case (i_type)
      2'b00: begin w_res_raw = w_lsl[WIDTH-1:0]; w_cout_raw = w_lsl[WIDTH];   end
      2'b01: begin w_res_raw = w_lsr[WIDTH:1];   w_cout_raw = w_lsr[0];       end
      2'b10: begin w_res_raw = w_asr[WIDTH:1];   w_cout_raw = w_asr[0];       end
      2'b11: begin w_res_raw = w_ror[WIDTH-1:0]; w_cout_raw = w_ror[WIDTH-1]; end
      default: begin w_res_raw = i_data; w_cout_raw = i_cin; end
    endcase
    o_result = (i_amount == '0) ? i_data : w_res_raw;
    o_cout   = (i_amount == '0) ? i_cin  : w_cout_raw;
  end

endmodule

// File: rtl/alu_multicycle.sv
// 16-op ALU with valid/ready input, registered result, NZCV flag register
// and an iterative shift-add multiplier (one partial product per clock).
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUControl,
  input  logic             set_flags,
  output logic [WIDTH-1:0] Result,
  output logic             out_valid,
  output logic [3:0]       ALUFlags
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int CW    = LOG2W + 1;

  alu_state_t       r_state, w_state_next;
  logic [WIDTH-1:0] r_result, r_mcand, r_mplier, r_acc;
  logic [CW-1:0]    r_count;
  logic             r_mul_s, r_out_valid;
  logic [3:0]       r_flags;

  alu_op_t          w_op;
  logic             w_accept, w_is_mul, w_mul_last;
  logic [WIDTH-1:0] w_add_x, w_add_y, w_res, w_shift_res, w_acc_next;
  logic             w_add_cin, w_add_v, w_shift_cout, w_c, w_v, w_flag_we;
  logic [WIDTH:0]   w_sum;
  logic [3:0]       w_flags_next;

  assign w_op       = alu_op_t'(ALUControl);
  assign in_ready   = (r_state == ST_IDLE) & ~reset;
  assign w_accept   = in_valid & in_ready;
  assign w_is_mul   = (w_op == OP_MUL) && (MUL_EN != 0);
  assign w_mul_last = (r_count == CW'(1));
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  assign Result    = r_result;
  assign out_valid = r_out_valid;
  assign ALUFlags  = r_flags;

  // All add/sub flavours share one adder; RSB swaps operands, SUB-types invert y.
  always_comb begin
    w_add_x   = a;
    w_add_y   = b;
    w_add_cin = 1'b0;
    case (w_op)
      OP_SUB:  begin w_add_y = ~b; w_add_cin = 1'b1;            end
      OP_ADC:  begin w_add_cin = r_flags[FLAG_C];               end
      OP_SBC:  begin w_add_y = ~b; w_add_cin = r_flags[FLAG_C]; end
      OP_RSB:  begin w_add_x = b; w_add_y = ~a; w_add_cin = 1'b1; end
      default: begin w_add_x = a; w_add_y = b; w_add_cin = 1'b0; end
    endcase
    w_sum   = {1'b0, w_add_x} + {1'b0, w_add_y} + {{WIDTH{1'b0}}, w_add_cin};
    w_add_v = (w_add_x[WIDTH-1] == w_add_y[WIDTH-1]) &&
              (w_sum[WIDTH-1] != w_add_x[WIDTH-1]);
  end

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .i_data   (a),
    .i_amount (b[LOG2W-1:0]),
    .i_type   (ALUControl[1:0]),
    .i_cin    (r_flags[FLAG_C]),
    .o_result (w_shift_res),
    .o_cout   (w_shift_cout)
  );

  // Single-cycle result and candidate flags; MUL here only covers the MUL_EN=0 case.
  always_comb begin
    w_res     = '0;
    w_c       = r_flags[FLAG_C];
    w_v       = r_flags[FLAG_V];
    w_flag_we = set_flags;
    case (w_op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_RSB: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_add_v;
      end
      OP_AND:  w_res = a & b;
      OP_ORR:  w_res = a | b;
      OP_EOR:  w_res = a ^ b;
      OP_BIC:  w_res = a & ~b;
      OP_MOV:  w_res = b;
      OP_MVN:  w_res = ~b;
      OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
        w_res = w_shift_res;
        w_c   = w_shift_cout;
      end
      OP_MUL: begin
        w_res     = '0;
        w_flag_we = 1'b0;
      end
      default: w_res = '0;
    endcase
    w_flags_next = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
  end

  // Next-state logic: a MUL parks the FSM in MUL_BUSY for WIDTH iterations.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_mul) w_state_next = ST_MUL_BUSY;
        else                      w_state_next = ST_IDLE;
      end
      ST_MUL_BUSY: begin
        if (w_mul_last) w_state_next = ST_IDLE;
        else            w_state_next = ST_MUL_BUSY;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Datapath registers; reset mid-MUL discards the partial product silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_flags     <= 4'b0000;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_count     <= '0;
      r_mul_s     <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (r_state == ST_MUL_BUSY) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count - CW'(1);
        if (w_mul_last) begin
          r_result    <= w_acc_next;
          r_out_valid <= 1'b1;
          if (r_mul_s) begin
            r_flags[FLAG_N] <= w_acc_next[WIDTH-1];
            r_flags[FLAG_Z] <= (w_acc_next == '0);
          end
        end
      end else if (w_accept) begin
        if (w_is_mul) begin
          r_mcand  <= a;
          r_mplier <= b;
          r_acc    <= '0;
          r_count  <= CW'(WIDTH);
          r_mul_s  <= set_flags;
        end else begin
          r_result    <= w_res;
          r_out_valid <= 1'b1;
          if (w_flag_we) r_flags <= w_flags_next;
        end
      end
    end
  end

endmodule
